anthem_stream_ctrl: RTL and testbench

Playback controller for the character-string datapath. It sequences reads from a registered character ROM and presents each character on a valid/ready output toward the display/UART side. Supported controls: start, stop, pause, loop and a programmable inter-character pacing interval. It sits between the top-level input switches (control) and the character ROM plus output register (datapath).

---
 rtl/anthem_stream_ctrl_if.sv | 32 +++
 rtl/anthem_stream_ctrl.sv | 139 +++++++++++++
 tb/tb_anthem_stream_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/anthem_stream_ctrl_if.sv
// rtl/anthem_stream_ctrl_if.sv - ROM read port and character output stream bundle
// Ports:
//   rom_addr   ROM read address (controller -> ROM)
//   rom_data   ROM read data, one cycle after rom_addr (ROM -> controller)
//   char_out   character toward the sink
//   char_valid char_out valid
//   char_ready sink accepts when char_valid && char_ready
interface anthem_stream_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic [7:0]        char_out;
    logic              char_valid;
    logic              char_ready;

    modport master (
        output rom_addr,
        input  rom_data,
        output char_out,
        output char_valid,
        input  char_ready
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  char_out,
        input  char_valid,
        output char_ready
    );
endinterface

// File: rtl/anthem_stream_ctrl.sv
// rtl/anthem_stream_ctrl.sv - character ROM playback sequencer with pause, loop and pacing
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   start, stop         launch playback / abort (stop wins)
//   pause, loop         freeze sequencing / restart from base at end of segment
//   cfg_base/len/div    segment base, length (0 = empty) and extra idle cycles per character
//   bus (master)        ROM read port and char_out/char_valid/char_ready stream
//   busy, done          not idle / one-cycle completion pulse
module anthem_stream_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_len,
    input  logic [DIV_W-1:0]  cfg_div,
    anthem_stream_ctrl_if.master bus,
    output logic              busy,
    output logic              done
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        LOAD    = 3'd2,
        PRESENT = 3'd3,
        PACE    = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0]  DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] cnt;
    logic [DIV_W-1:0]  pace;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] len_q;
    logic [DIV_W-1:0]  div_q;
    logic [7:0]        char_q;
    logic              valid_q;

    assign bus.rom_addr   = addr;
    assign bus.char_out   = char_q;
    assign bus.char_valid = valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr    <= '0;
            cnt     <= '0;
            pace    <= '0;
            base_q  <= '0;
            len_q   <= '0;
            div_q   <= '0;
            char_q  <= '0;
            valid_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && stop) begin
                // Abort: char_out deliberately keeps its last value.
                state   <= IDLE;
                valid_q <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !stop) begin
                            if (cfg_len != '0) begin
                                base_q <= cfg_base;
                                len_q  <= cfg_len;
                                div_q  <= cfg_div;
                                addr   <= cfg_base;
                                cnt    <= '0;
                                busy   <= 1'b1;
                                state  <= FETCH;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    FETCH: begin
                        // The ROM samples addr on this edge; data is ready in LOAD.
                        if (!pause) begin
                            state <= LOAD;
                        end
                    end
                    LOAD: begin
                        char_q  <= bus.rom_data;
                        valid_q <= 1'b1;
                        state   <= PRESENT;
                    end
                    PRESENT: begin
                        if (bus.char_ready) begin
                            valid_q <= 1'b0;
                            pace    <= div_q;
                            if (cnt == len_q - ADDR_ONE) begin
                                if (loop) begin
                                    addr  <= base_q;
                                    cnt   <= '0;
                                    state <= PACE;
                                end else begin
                                    done  <= 1'b1;
                                    busy  <= 1'b0;
                                    state <= IDLE;
                                end
                            end else begin
                                addr  <= addr + ADDR_ONE;
                                cnt   <= cnt + ADDR_ONE;
                                state <= PACE;
                            end
                        end
                    end
                    PACE: begin
                        // pace=0 still spends one cycle here, so div=0 costs one cycle.
                        if (!pause) begin
                            if (pace == '0) begin
                                state <= FETCH;
                            end else begin
                                pace <= pace - DIV_ONE;
                            end
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_anthem_stream_ctrl.sv
// tb/tb_anthem_stream_ctrl.sv - self-checking bench for anthem_stream_ctrl
module tb_anthem_stream_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic        pause;
    logic        loop;
    logic [7:0]  cfg_base;
    logic [7:0]  cfg_len;
    logic [15:0] cfg_div;
    logic        busy;
    logic        done;

    anthem_stream_ctrl_if #(.ADDR_W(8)) bus ();

    anthem_stream_ctrl #(.ADDR_W(8), .DIV_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .loop     (loop),
        .cfg_base (cfg_base),
        .cfg_len  (cfg_len),
        .cfg_div  (cfg_div),
        .bus      (bus),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    logic [7:0] rom [256];
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    bit checking = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Behavioural model: a character becomes visible after a count of cycles
    // (2 after start, div+3 after an acceptance); pause stalls the count except
    // on the final cycle, where the ROM byte is already being captured.
    bit         m_busy = 0, m_valid = 0, m_done = 0;
    logic [7:0] m_char = 0, m_addr = 0, m_base = 0, m_len = 0, m_idx = 0;
    int         m_div = 0, m_d = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 0; m_valid <= 0; m_done <= 0;
            m_char <= 0; m_addr <= 0; m_idx <= 0; m_d <= 0;
            m_base <= 0; m_len <= 0; m_div <= 0;
        end else begin
            m_done <= 0;
            if (!m_busy) begin
                if (start && !stop) begin
                    if (cfg_len != 0) begin
                        m_base <= cfg_base; m_len <= cfg_len; m_div <= int'(cfg_div);
                        m_addr <= cfg_base; m_idx <= 0; m_busy <= 1; m_d <= 2;
                    end else begin
                        m_done <= 1;
                    end
                end
            end else if (stop) begin
                m_busy <= 0; m_valid <= 0;
            end else if (m_valid) begin
                if (bus.char_ready) begin
                    m_valid <= 0;
                    if (m_idx == m_len - 8'd1) begin
                        if (loop) begin
                            m_addr <= m_base; m_idx <= 0; m_d <= m_div + 3;
                        end else begin
                            m_busy <= 0; m_done <= 1;
                        end
                    end else begin
                        m_addr <= m_addr + 8'd1; m_idx <= m_idx + 8'd1; m_d <= m_div + 3;
                    end
                end
            end else if (!(pause && m_d >= 2)) begin
                if (m_d == 1) begin
                    m_valid <= 1; m_char <= rom[m_addr]; m_d <= 0;
                end else begin
                    m_d <= m_d - 1;
                end
            end
        end
    end

    int         acc_cyc[$];
    logic [7:0] acc_chr[$];
    int         done_cyc[$];

    always @(negedge clk) begin
        if (checking) begin
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("char_valid", bus.char_valid, m_valid);
            check("char_out", bus.char_out, m_char);
            check("rom_addr", bus.rom_addr, m_addr);
        end
        if (bus.char_valid === 1'b1 && bus.char_ready === 1'b1) begin
            acc_cyc.push_back(cycle);
            acc_chr.push_back(bus.char_out);
        end
        if (done === 1'b1) done_cyc.push_back(cycle);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_logs();
        acc_cyc.delete();
        acc_chr.delete();
        done_cyc.delete();
    endtask

    task automatic launch(input logic [7:0] b, input logic [7:0] l, input logic [15:0] d);
        cfg_base = b; cfg_len = l; cfg_div = d;
        start = 1; step(1); start = 0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int t = 0;
        while (done_cyc.size() == 0 && t < budget) begin step(1); t++; end
        check(name, done_cyc.size() != 0, 1);
        step(2);
    endtask

    task automatic wait_acc(input string name, input int n, input int budget);
        int t = 0;
        while (acc_chr.size() < n && t < budget) begin step(1); t++; end
        check(name, acc_chr.size() >= n, 1);
    endtask

    task automatic wait_valid_after(input string name, input int n, input int budget);
        int t = 0;
        while (!(acc_chr.size() == n && bus.char_valid === 1'b1) && t < budget) begin step(1); t++; end
        check(name, t < budget, 1);
    endtask

    task automatic check_gap(input string name, input int i, input int exp);
        if (acc_cyc.size() > i) check(name, acc_cyc[i] - acc_cyc[i-1], exp);
        else check(name, acc_cyc.size(), i + 1);
    endtask

    logic [7:0] taj [9];
    logic [7:0] wrap_exp [8];

    initial begin
        taj = '{8'h54, 8'h61, 8'h6A, 8'h75, 8'h6D, 8'h75, 8'h6C, 8'h63, 8'h6F};
        for (int i = 0; i < 256; i++) rom[i] = 8'(i) ^ 8'hA5;
        for (int i = 0; i < 9; i++) rom[i] = taj[i];
        rom[8'hFE] = 8'hA1;
        rom[8'hFF] = 8'hB2;
        wrap_exp = '{8'hA1, 8'hB2, 8'h54, 8'h61, 8'hA1, 8'hB2, 8'h54, 8'h61};

        rst = 1; start = 0; stop = 0; pause = 0; loop = 0;
        cfg_base = 0; cfg_len = 0; cfg_div = 0; bus.char_ready = 1;
        step(1);
        checking = 1;
        step(1);
        check("reset_rom_addr", bus.rom_addr, 8'h00);
        check("reset_char_out", bus.char_out, 8'h00);
        check("reset_valid", bus.char_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        rst = 0;
        step(1);

        // Plain playback, div=0.
        clear_logs();
        launch(8'd0, 8'd9, 16'd0);
        check("s1_busy_after_start", busy, 1);
        wait_done("s1_done_seen", 200);
        check("s1_count", acc_chr.size(), 9);
        for (int i = 0; i < 9 && i < acc_chr.size(); i++) check("s1_char", acc_chr[i], taj[i]);
        for (int i = 1; i < 9; i++) check_gap("s1_gap", i, 4);
        check("s1_done_count", done_cyc.size(), 1);
        if (done_cyc.size() > 0 && acc_cyc.size() == 9) check("s1_done_time", done_cyc[0], acc_cyc[8] + 1);
        check("s1_idle", busy, 0);

        // div=3 with backpressure on the third character.
        clear_logs();
        launch(8'd0, 8'd9, 16'd3);
        wait_valid_after("s2_third_valid", 2, 100);
        bus.char_ready = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("s2_hold_char", bus.char_out, 8'h6A);
            check("s2_hold_valid", bus.char_valid, 1);
        end
        bus.char_ready = 1;
        wait_done("s2_done_seen", 200);
        check("s2_count", acc_chr.size(), 9);
        for (int i = 0; i < 9 && i < acc_chr.size(); i++) check("s2_char", acc_chr[i], taj[i]);
        check_gap("s2_gap1", 1, 7);
        check_gap("s2_gap2", 2, 12);
        check_gap("s2_gap3", 3, 7);

        // Wrap and loop, loop dropped in the second pass.
        clear_logs();
        loop = 1;
        launch(8'hFE, 8'd4, 16'd0);
        wait_acc("s3_six", 6, 200);
        check("s3_no_early_done", done_cyc.size(), 0);
        loop = 0;
        wait_done("s3_done_seen", 200);
        check("s3_count", acc_chr.size(), 8);
        for (int i = 0; i < 8 && i < acc_chr.size(); i++) check("s3_char", acc_chr[i], wrap_exp[i]);
        check("s3_done_count", done_cyc.size(), 1);
        if (done_cyc.size() > 0 && acc_cyc.size() == 8) check("s3_done_time", done_cyc[0], acc_cyc[7] + 1);

        // Pause in PACE stretches the gap; pause in PRESENT does not block acceptance.
        clear_logs();
        launch(8'd0, 8'd4, 16'd2);
        wait_acc("s4_first", 1, 100);
        pause = 1; step(10); pause = 0;
        wait_valid_after("s4_third_valid", 2, 100);
        pause = 1; step(1); pause = 0;
        wait_done("s4_done_seen", 200);
        check_gap("s4_gap_paused", 1, 16);
        check_gap("s4_gap_present_pause", 2, 6);
        check_gap("s4_gap_plain", 3, 6);

        // Stop while stalled, then replay from base.
        clear_logs();
        bus.char_ready = 0;
        launch(8'd3, 8'd5, 16'd1);
        wait_valid_after("s5_valid", 0, 50);
        stop = 1; step(1); stop = 0;
        check("s5_valid_after_stop", bus.char_valid, 0);
        check("s5_busy_after_stop", busy, 0);
        check("s5_done_after_stop", done, 0);
        check("s5_no_accept", acc_chr.size(), 0);
        bus.char_ready = 1;
        launch(8'd3, 8'd5, 16'd1);
        wait_done("s5_done_seen", 200);
        check("s5_count", acc_chr.size(), 5);
        for (int i = 0; i < 5 && i < acc_chr.size(); i++) check("s5_char", acc_chr[i], taj[3+i]);

        // Reset mid-segment, then an empty segment.
        clear_logs();
        launch(8'd0, 8'd9, 16'd0);
        step(6);
        rst = 1; step(1); rst = 0;
        check("s6_rom_addr", bus.rom_addr, 8'h00);
        check("s6_char_out", bus.char_out, 8'h00);
        check("s6_valid", bus.char_valid, 0);
        check("s6_busy", busy, 0);
        check("s6_done", done, 0);
        launch(8'd5, 8'd0, 16'd0);
        check("s6_empty_done", done, 1);
        check("s6_empty_busy", busy, 0);
        step(1);
        check("s6_empty_done_pulse", done, 0);
        check("s6_empty_busy2", busy, 0);

        // Randomized traffic checked cycle by cycle against the model.
        for (int r = 0; r < 30; r++) begin
            for (int c = 0; c < 80; c++) begin
                bus.char_ready = ($urandom_range(0, 3) != 0);
                pause    = ($urandom_range(0, 7) == 0);
                stop     = ($urandom_range(0, 59) == 0);
                loop     = ($urandom_range(0, 3) != 0);
                start    = ($urandom_range(0, 9) == 0);
                rst      = ($urandom_range(0, 149) == 0);
                cfg_base = 8'($urandom);
                cfg_len  = 8'($urandom_range(0, 5));
                cfg_div  = 16'($urandom_range(0, 3));
                step(1);
            end
            start = 0; rst = 0; pause = 0;
            stop = 1; step(1); stop = 0;
            step(1);
        end

        checking = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
